// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: opcodes, flag bundle, FSM states.
// The optional multiplier is enabled by defining ALU_MUL_EN.
package alu_pkg;

   localparam int MUL_CYC = 8;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_ADC   = 4'h1,
      OP_SUB   = 4'h2,
      OP_AND   = 4'h3,
      OP_OR    = 4'h4,
      OP_XOR   = 4'h5,
      OP_SHL   = 4'h6,
      OP_SHR   = 4'h7,
      OP_ROL   = 4'h8,
      OP_PASSB = 4'h9,
      OP_CLC   = 4'hA,
      OP_MUL   = 4'hB,
      OP_NOP0  = 4'hC,
      OP_NOP1  = 4'hD,
      OP_NOP2  = 4'hE,
      OP_NOP3  = 4'hF
   } op_t;

   typedef struct packed {
      logic c;
      logic z;
      logic p;
   } flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_flags_unit_if.sv
// Operand/result bus between control + register file and the ALU stage.
// master = control/reg-file side, slave = ALU.
interface alu_flags_unit_if #(parameter int W = 8);
   import alu_pkg::*;

   logic         op_valid;
   op_t          op;
   logic [W-1:0] datA;
   logic [W-1:0] datB;
   logic [W-1:0] rslt;
   logic         rslt_vld;
   logic         busy;
   logic         carry_flag;
   logic         zero_flag;
   logic         par_flag;

   modport master (
      output op_valid, op, datA, datB,
      input  rslt, rslt_vld, busy, carry_flag, zero_flag, par_flag
   );

   modport slave (
      input  op_valid, op, datA, datB,
      output rslt, rslt_vld, busy, carry_flag, zero_flag, par_flag
   );
endinterface

// File: rtl/shift_add_mul.sv
// Iterative W x W -> 2W unsigned multiplier, one partial product per cycle.
// start latches operands; done is high during the final iteration cycle and
// prod carries the completed product in that same cycle.
module shift_add_mul #(
   parameter int W   = 8,
   parameter int CYC = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] prod
);
   localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

   logic           active;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] acc_nxt;

   // Add the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_nxt = acc + (mplier[0] ? mcand : '0);
      done    = active && (cnt == CW'(CYC - 1));
      prod    = acc_nxt;
   end

   // Operand latch on start, then one shift-add step per cycle until done.
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
      end else if (active) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) active <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_flags_unit.sv
// 8-bit execute stage: single-cycle ALU ops, C/Z/P flag register and an
// optional iterative MUL (macro ALU_MUL_EN) that stalls control via busy.
// Results and flags are registered at the accept edge; rslt_vld pulses for
// the following cycle and feeds the register-file write enable.
module alu_flags_unit #(
   parameter int W       = 8,
   parameter int MUL_CYC = alu_pkg::MUL_CYC
) (
   input  logic              clk,
   input  logic              reset,
   alu_flags_unit_if.slave   bus
);
   import alu_pkg::*;

   state_t       state_q, state_d;
   logic [W-1:0] rslt_q, rslt_d;
   logic         vld_q, vld_d;
   flags_t       flg_q, flg_d;
   logic [W:0]   sum, diff;
   logic         cin;
   logic         accept;

`ifdef ALU_MUL_EN
   logic           mul_start;
   logic           mul_done;
   logic [2*W-1:0] mul_prod;

   shift_add_mul #(.W(W), .CYC(MUL_CYC)) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (mul_start),
      .a     (bus.datA),
      .b     (bus.datB),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`endif

   // Next-state, result and flag decode; operands are only accepted in IDLE.
   always_comb begin
      state_d = state_q;
      rslt_d  = rslt_q;
      vld_d   = 1'b0;
      flg_d   = flg_q;
`ifdef ALU_MUL_EN
      mul_start = 1'b0;
`else
      state_d = ST_IDLE;
`endif
      cin    = (bus.op == OP_ADC) && flg_q.c;
      sum    = {1'b0, bus.datA} + {1'b0, bus.datB} + {{W{1'b0}}, cin};
      diff   = {1'b0, bus.datA} - {1'b0, bus.datB};
      accept = bus.op_valid && (state_q == ST_IDLE);

      if (accept) begin
         case (bus.op)
            OP_ADD, OP_ADC: begin
               {flg_d.c, rslt_d} = sum;
               vld_d = 1'b1;
            end
            OP_SUB: begin
               // diff[W] is the borrow out of the unsigned subtract
               {flg_d.c, rslt_d} = diff;
               vld_d = 1'b1;
            end
            OP_AND:   begin rslt_d = bus.datA & bus.datB; vld_d = 1'b1; end
            OP_OR:    begin rslt_d = bus.datA | bus.datB; vld_d = 1'b1; end
            OP_XOR:   begin rslt_d = bus.datA ^ bus.datB; vld_d = 1'b1; end
            OP_PASSB: begin rslt_d = bus.datB;            vld_d = 1'b1; end
            OP_SHL: begin
               rslt_d  = bus.datA << 1;
               flg_d.c = bus.datA[W-1];
               vld_d   = 1'b1;
            end
            OP_SHR: begin
               rslt_d  = bus.datA >> 1;
               flg_d.c = bus.datA[0];
               vld_d   = 1'b1;
            end
            OP_ROL: begin
               rslt_d  = {bus.datA[W-2:0], bus.datA[W-1]};
               flg_d.c = bus.datA[W-1];
               vld_d   = 1'b1;
            end
            OP_CLC: flg_d.c = 1'b0;
`ifdef ALU_MUL_EN
            OP_MUL: begin
               mul_start = 1'b1;
               state_d   = ST_MUL;
            end
`endif
            default: ;
         endcase
      end

`ifdef ALU_MUL_EN
      // Final iteration: low byte is the result, any high-byte bit sets C.
      if (state_q == ST_MUL && mul_done) begin
         rslt_d  = mul_prod[W-1:0];
         flg_d.c = |mul_prod[2*W-1:W];
         vld_d   = 1'b1;
         state_d = ST_IDLE;
      end
`endif

      // Z and P track the result only when a new result is written.
      if (vld_d) begin
         flg_d.z = (rslt_d == '0);
         flg_d.p = ^rslt_d;
      end
   end

   // State, result, strobe and flag registers; reset also aborts a MUL.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rslt_q  <= '0;
         vld_q   <= 1'b0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         rslt_q  <= rslt_d;
         vld_q   <= vld_d;
         flg_q   <= flg_d;
      end
   end

   assign bus.rslt       = rslt_q;
   assign bus.rslt_vld   = vld_q;
   assign bus.carry_flag = flg_q.c;
   assign bus.zero_flag  = flg_q.z;
   assign bus.par_flag   = flg_q.p;
`ifdef ALU_MUL_EN
   assign bus.busy       = (state_q == ST_MUL);
`else
   assign bus.busy       = 1'b0;
`endif
endmodule

// File: tb/tb_alu_flags_unit.sv
// Directed bench for alu_flags_unit. Observed vector layout:
// {rslt[7:0], rslt_vld, busy, C, Z, P}. MUL checks depend on ALU_MUL_EN.
module tb_alu_flags_unit;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_flags_unit_if #(.W(8)) bus ();

   alu_flags_unit #(.W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input op_t o, input logic [7:0] a, input logic [7:0] b);
      bus.op_valid = v;
      bus.op       = o;
      bus.datA     = a;
      bus.datB     = b;
   endtask

   function automatic logic [12:0] obs();
      return {bus.rslt, bus.rslt_vld, bus.busy, bus.carry_flag, bus.zero_flag, bus.par_flag};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, OP_ADD, 8'hFF, 8'hFF);
      for (int i = 0; i < 2; i++) begin
         edge_wait();
         n_checks++;
         if (obs() !== {8'h00, 5'b00000}) begin
            n_fail++;
            $display("FAIL reset_%0d: got %h exp %h", i, obs(), {8'h00, 5'b00000});
         end
      end
      reset = 1'b0;
      drive(1'b0, OP_ADD, 8'h00, 8'h00);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h00, 5'b00000}) begin
         n_fail++;
         $display("FAIL reset_release: got %h exp %h", obs(), {8'h00, 5'b00000});
      end
   endtask

   task automatic test_add();
      drive(1'b1, OP_ADD, 8'hF0, 8'h20);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h10, 5'b10101}) begin
         n_fail++;
         $display("FAIL add: got %h exp %h", obs(), {8'h10, 5'b10101});
      end
      drive(1'b0, OP_ADD, 8'h00, 8'h00);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h10, 5'b00101}) begin
         n_fail++;
         $display("FAIL add_pulse_end: got %h exp %h", obs(), {8'h10, 5'b00101});
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, OP_ADD, 8'hF0, 8'h20);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h10, 5'b10101}) begin
         n_fail++;
         $display("FAIL b2b_add: got %h exp %h", obs(), {8'h10, 5'b10101});
      end
      drive(1'b1, OP_ADC, 8'h01, 8'h01);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h03, 5'b10000}) begin
         n_fail++;
         $display("FAIL b2b_adc: got %h exp %h", obs(), {8'h03, 5'b10000});
      end
      drive(1'b1, OP_SUB, 8'h05, 8'h06);
      edge_wait();
      n_checks++;
      if (obs() !== {8'hFF, 5'b10100}) begin
         n_fail++;
         $display("FAIL b2b_sub: got %h exp %h", obs(), {8'hFF, 5'b10100});
      end
   endtask

   task automatic test_clc_xor();
      drive(1'b1, OP_CLC, 8'h00, 8'h00);
      edge_wait();
      n_checks++;
      if (obs() !== {8'hFF, 5'b00000}) begin
         n_fail++;
         $display("FAIL clc: got %h exp %h", obs(), {8'hFF, 5'b00000});
      end
      drive(1'b1, OP_XOR, 8'h5A, 8'h5A);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h00, 5'b10010}) begin
         n_fail++;
         $display("FAIL xor_zero: got %h exp %h", obs(), {8'h00, 5'b10010});
      end
   endtask

   task automatic test_ops();
      op_t        t_op[9];
      logic [7:0] t_a[9];
      logic [7:0] t_b[9];
      logic [7:0] t_r[9];
      logic [2:0] t_f[9];   // {C,Z,P}
      t_op = '{OP_SHL, OP_AND, OP_SHR, OP_OR, OP_ROL, OP_PASSB, OP_ADD, OP_SUB, OP_ADC};
      t_a  = '{8'h81, 8'hF0, 8'h02, 8'h0F, 8'h81, 8'h77, 8'hFF, 8'h10, 8'hFF};
      t_b  = '{8'h00, 8'h3C, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h10, 8'h00};
      t_r  = '{8'h02, 8'h30, 8'h01, 8'h3F, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFF};
      t_f  = '{3'b101, 3'b100, 3'b001, 3'b000, 3'b100, 3'b110, 3'b110, 3'b010, 3'b000};
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, t_op[i], t_a[i], t_b[i]);
         edge_wait();
         n_checks++;
         if (obs() !== {t_r[i], 2'b10, t_f[i]}) begin
            n_fail++;
            $display("FAIL ops_%0d: got %h exp %h", i, obs(), {t_r[i], 2'b10, t_f[i]});
         end
      end
      drive(1'b1, op_t'(4'hE), 8'h12, 8'h34);
      edge_wait();
      n_checks++;
      if (obs() !== {8'hFF, 5'b00000}) begin
         n_fail++;
         $display("FAIL nop: got %h exp %h", obs(), {8'hFF, 5'b00000});
      end
      drive(1'b0, OP_ADD, 8'h00, 8'h00);
   endtask

   task automatic test_mul();
      drive(1'b1, OP_ADD, 8'h00, 8'h00);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h00, 5'b10010}) begin
         n_fail++;
         $display("FAIL mul_pre: got %h exp %h", obs(), {8'h00, 5'b10010});
      end
      drive(1'b1, OP_MUL, 8'h10, 8'h11);
      edge_wait();
`ifdef ALU_MUL_EN
      drive(1'b1, OP_ADD, 8'h01, 8'h01);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (obs() !== {8'h00, 5'b01010}) begin
            n_fail++;
            $display("FAIL mul_busy_%0d: got %h exp %h", i, obs(), {8'h00, 5'b01010});
         end
         edge_wait();
      end
      drive(1'b0, OP_ADD, 8'h00, 8'h00);
      n_checks++;
      if (obs() !== {8'h10, 5'b10101}) begin
         n_fail++;
         $display("FAIL mul_result: got %h exp %h", obs(), {8'h10, 5'b10101});
      end
      edge_wait();
      n_checks++;
      if (obs() !== {8'h10, 5'b00101}) begin
         n_fail++;
         $display("FAIL mul_pulse_end: got %h exp %h", obs(), {8'h10, 5'b00101});
      end
`else
      drive(1'b0, OP_ADD, 8'h00, 8'h00);
      for (int i = 0; i < 9; i++) begin
         n_checks++;
         if (obs() !== {8'h00, 5'b00010}) begin
            n_fail++;
            $display("FAIL mul_off_%0d: got %h exp %h", i, obs(), {8'h00, 5'b00010});
         end
         edge_wait();
      end
`endif
   endtask

   task automatic test_mul_reset();
      logic [12:0] exp_busy;
      drive(1'b1, OP_ADD, 8'hF0, 8'h20);
      edge_wait();
      n_checks++;
      if (obs() !== {8'h10, 5'b10101}) begin
         n_fail++;
         $display("FAIL mrst_pre: got %h exp %h", obs(), {8'h10, 5'b10101});
      end
      drive(1'b1, OP_MUL, 8'h03, 8'h04);
      edge_wait();
      drive(1'b0, OP_ADD, 8'h00, 8'h00);
`ifdef ALU_MUL_EN
      exp_busy = {8'h10, 5'b01101};
`else
      exp_busy = {8'h10, 5'b00101};
`endif
      n_checks++;
      if (obs() !== exp_busy) begin
         n_fail++;
         $display("FAIL mrst_busy1: got %h exp %h", obs(), exp_busy);
      end
      for (int i = 0; i < 3; i++) edge_wait();
      n_checks++;
      if (obs() !== exp_busy) begin
         n_fail++;
         $display("FAIL mrst_busy4: got %h exp %h", obs(), exp_busy);
      end
      reset = 1'b1;
      edge_wait();
      reset = 1'b0;
      n_checks++;
      if (obs() !== {8'h00, 5'b00000}) begin
         n_fail++;
         $display("FAIL mrst_abort: got %h exp %h", obs(), {8'h00, 5'b00000});
      end
      for (int i = 0; i < 10; i++) begin
         edge_wait();
         n_checks++;
         if (obs() !== {8'h00, 5'b00000}) begin
            n_fail++;
            $display("FAIL mrst_quiet_%0d: got %h exp %h", i, obs(), {8'h00, 5'b00000});
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, OP_ADD, 8'h00, 8'h00);
      test_reset();
      test_add();
      test_back_to_back();
      test_clc_xor();
      test_ops();
      test_mul();
      test_mul_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
